// File: rtl/wb_cmd_master_if.sv
// Command-stream and Wishbone B4 pipelined bus signals of wb_cmd_master.
// The master modport is the bus-master view; the slave modport drives commands and models the bus slave.
interface wb_cmd_master_if #(
    parameter int ADR_W = 11,
    parameter int DAT_W = 16
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [ADR_W-1:0] req_adr;
    logic [DAT_W-1:0] req_dat;
    logic             rsp_valid;
    logic             rsp_we;
    logic [DAT_W-1:0] rsp_dat;
    logic             rsp_err;
    logic             wb_cyc;
    logic             wb_stb;
    logic             wb_we;
    logic [ADR_W-1:0] wb_adr;
    logic [DAT_W-1:0] wb_dat_o;
    logic [DAT_W-1:0] wb_dat_i;
    logic             wb_ack;
    logic             wb_stall;

    modport master (
        input  req_valid, req_we, req_adr, req_dat, wb_dat_i, wb_ack, wb_stall,
        output req_ready, rsp_valid, rsp_we, rsp_dat, rsp_err,
               wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o
    );

    modport slave (
        output req_valid, req_we, req_adr, req_dat, wb_dat_i, wb_ack, wb_stall,
        input  req_ready, rsp_valid, rsp_we, rsp_dat, rsp_err,
               wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone B4 pipelined single-beat master driven by a valid/ready command stream.
// Define WB_TIMEOUT_EN to abort transfers that see no ACK for TIMEOUT cycles.
module wb_cmd_master #(
    parameter int ADR_W   = 11,
    parameter int DAT_W   = 16,
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    wb_cmd_master_if.master bus
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUS  = 1'b1;
    localparam logic [4:0] MAX_L   = 5'(MAX_OUT);

    generate
        if (MAX_OUT < 1 || MAX_OUT > 15 || TIMEOUT < 1) begin : g_bad_cfg
            $error("wb_cmd_master: MAX_OUT must be 1..15 and TIMEOUT at least 1");
        end
    endgenerate

    logic [0:0]       r_state;
    logic [3:0]       r_cnt;
    logic             r_stb;
    logic             r_we;
    logic [ADR_W-1:0] r_adr;
    logic [DAT_W-1:0] r_dat;
    logic             r_rsp_valid;
    logic             r_rsp_we;
    logic [DAT_W-1:0] r_rsp_dat;
    logic             r_rsp_err;

    logic             w_issue;
    logic             w_ack;
    logic             w_abort;
    logic             w_slot_ok;
    logic             w_room_ok;
    logic             w_dir_ok;
    logic             w_ready;
    logic             w_accept;
    logic [3:0]       w_cnt_nxt;
    logic             w_stb_nxt;
    logic [0:0]       w_state_nxt;

    assign w_issue   = r_stb & ~bus.wb_stall;
    // An ACK with nothing outstanding is a slave protocol error and is dropped.
    assign w_ack     = bus.wb_ack & (r_cnt != 4'd0);
    assign w_slot_ok = ~r_stb | w_issue;
    assign w_room_ok = (({1'b0, r_cnt} + {4'd0, r_stb}) < MAX_L);
    assign w_dir_ok  = (bus.req_we == r_we) | ((r_cnt == 4'd0) & ~r_stb);
    assign w_ready   = ~reset & ~w_abort & w_slot_ok & w_room_ok & w_dir_ok;
    assign w_accept  = bus.req_valid & w_ready;

`ifdef WB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

    logic [TO_W-1:0] r_to_cnt;
    logic            w_to_run;

    assign w_to_run = (r_cnt != 4'd0) | r_stb;
    assign w_abort  = w_to_run & (r_to_cnt == TO_W'(TIMEOUT));

    // Cycles since the last bus progress while work is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if (w_abort || w_issue || w_ack || !w_to_run) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end
`else
    assign w_abort = 1'b0;
`endif

    // Outstanding count, pending strobe and bus state for the next cycle.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_stb_nxt   = r_stb;
        w_state_nxt = r_state;
        if (w_abort) begin
            w_cnt_nxt = 4'd0;
        end else if (w_issue && !w_ack) begin
            w_cnt_nxt = r_cnt + 4'd1;
        end else if (!w_issue && w_ack) begin
            w_cnt_nxt = r_cnt - 4'd1;
        end else begin
            w_cnt_nxt = r_cnt;
        end
        if (w_abort) begin
            w_stb_nxt = 1'b0;
        end else if (w_accept) begin
            w_stb_nxt = 1'b1;
        end else if (w_issue) begin
            w_stb_nxt = 1'b0;
        end else begin
            w_stb_nxt = r_stb;
        end
        // Leaving BUS on the edge that retires the last beat drops cyc right after the final ACK.
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_BUS;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUS: begin
                if ((w_cnt_nxt == 4'd0) && !w_stb_nxt) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_BUS;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus-side state; address, data and direction only change on an accepted command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_dat   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_stb   <= w_stb_nxt;
            if (w_accept) begin
                r_we  <= bus.req_we;
                r_adr <= bus.req_adr;
                r_dat <= bus.req_dat;
            end
        end
    end

    // Response pulse; all outstanding beats share r_we since direction changes drain the bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_we    <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_abort) begin
            r_rsp_valid <= 1'b1;
            r_rsp_we    <= r_we;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b1;
        end else if (w_ack) begin
            r_rsp_valid <= 1'b1;
            r_rsp_we    <= r_we;
            r_rsp_dat   <= r_we ? '0 : bus.wb_dat_i;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_we    = r_rsp_we;
    assign bus.rsp_dat   = r_rsp_dat;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.wb_cyc    = (r_state == ST_BUS);
    assign bus.wb_stb    = r_stb;
    assign bus.wb_we     = r_we;
    assign bus.wb_adr    = r_adr;
    assign bus.wb_dat_o  = r_dat;
endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed self-checking bench for wb_cmd_master; the bench plays command source and bus slave.
module tb_wb_cmd_master;
    localparam int ADR_W   = 11;
    localparam int DAT_W   = 16;
    localparam int MAX_OUT = 4;
    localparam int TIMEOUT = 255;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    wb_cmd_master_if #(.ADR_W(ADR_W), .DAT_W(DAT_W)) bus ();

    wb_cmd_master #(
        .ADR_W(ADR_W), .DAT_W(DAT_W), .MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_req(input logic v, input logic we, input logic [ADR_W-1:0] adr,
                             input logic [DAT_W-1:0] dat);
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_adr   = adr;
        bus.req_dat   = dat;
    endtask

    task automatic drive_slv(input logic ack, input logic stall, input logic [DAT_W-1:0] dat);
        bus.wb_ack   = ack;
        bus.wb_stall = stall;
        bus.wb_dat_i = dat;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        drive_req(1'b0, 1'b0, 11'h000, 16'h0000);
        drive_slv(1'b0, 1'b0, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cyc", bus.wb_cyc, 32'd0);
        chk("rst_stb", bus.wb_stb, 32'd0);
        chk("rst_ready", bus.req_ready, 32'd0);
        chk("rst_rsp", bus.rsp_valid, 32'd0);
        chk("rst_adr", bus.wb_adr, 32'd0);
        reset = 1'b0;

        // Single write, zero-wait slave; read data on the bus must not leak into a write response.
        step(); drive_req(1'b1, 1'b1, 11'h004, 16'h00A5); settle();
        chk("wr_ready", bus.req_ready, 32'd1);
        step(); drive_req(1'b0, 1'b0, 11'h000, 16'h0000); settle();
        chk("wr_stb", bus.wb_stb, 32'd1);
        chk("wr_cyc", bus.wb_cyc, 32'd1);
        chk("wr_adr", bus.wb_adr, 32'h004);
        chk("wr_dat", bus.wb_dat_o, 32'h00A5);
        chk("wr_we", bus.wb_we, 32'd1);
        step(); drive_slv(1'b1, 1'b0, 16'hDEAD); settle();
        chk("wr_stb_drop", bus.wb_stb, 32'd0);
        chk("wr_cyc_hold", bus.wb_cyc, 32'd1);
        chk("wr_rsp_early", bus.rsp_valid, 32'd0);
        step(); drive_slv(1'b0, 1'b0, 16'h0000); settle();
        chk("wr_rsp", bus.rsp_valid, 32'd1);
        chk("wr_rsp_we", bus.rsp_we, 32'd1);
        chk("wr_rsp_dat", bus.rsp_dat, 32'd0);
        chk("wr_cyc_drop", bus.wb_cyc, 32'd0);
        chk("wr_adr_hold", bus.wb_adr, 32'h004);
        step(); settle();
        chk("wr_rsp_once", bus.rsp_valid, 32'd0);

        // Four back-to-back reads, slave ACKs one cycle after each issue.
        step(); drive_req(1'b1, 1'b0, 11'h010, 16'h0000); settle();
        chk("b2b_ready0", bus.req_ready, 32'd1);
        step(); drive_req(1'b1, 1'b0, 11'h011, 16'h0000); settle();
        chk("b2b_stb1", bus.wb_stb, 32'd1);
        chk("b2b_adr1", bus.wb_adr, 32'h010);
        step(); drive_req(1'b1, 1'b0, 11'h012, 16'h0000); drive_slv(1'b1, 1'b0, 16'h1111); settle();
        chk("b2b_stb2", bus.wb_stb, 32'd1);
        chk("b2b_adr2", bus.wb_adr, 32'h011);
        step(); drive_req(1'b1, 1'b0, 11'h013, 16'h0000); drive_slv(1'b1, 1'b0, 16'h2222); settle();
        chk("b2b_stb3", bus.wb_stb, 32'd1);
        chk("b2b_adr3", bus.wb_adr, 32'h012);
        chk("b2b_rsp1", bus.rsp_valid, 32'd1);
        chk("b2b_dat1", bus.rsp_dat, 32'h1111);
        step(); drive_req(1'b0, 1'b0, 11'h000, 16'h0000); drive_slv(1'b1, 1'b0, 16'h3333); settle();
        chk("b2b_stb4", bus.wb_stb, 32'd1);
        chk("b2b_adr4", bus.wb_adr, 32'h013);
        chk("b2b_dat2", bus.rsp_dat, 32'h2222);
        step(); drive_slv(1'b1, 1'b0, 16'h4444); settle();
        chk("b2b_stb_end", bus.wb_stb, 32'd0);
        chk("b2b_cyc_hold", bus.wb_cyc, 32'd1);
        chk("b2b_dat3", bus.rsp_dat, 32'h3333);
        step(); drive_slv(1'b0, 1'b0, 16'h0000); settle();
        chk("b2b_rsp4", bus.rsp_valid, 32'd1);
        chk("b2b_rsp4_we", bus.rsp_we, 32'd0);
        chk("b2b_dat4", bus.rsp_dat, 32'h4444);
        chk("b2b_cyc_drop", bus.wb_cyc, 32'd0);

        // Slave stalls the second write for three cycles.
        step(); drive_req(1'b1, 1'b1, 11'h020, 16'hAAAA); settle();
        chk("st_ready0", bus.req_ready, 32'd1);
        step(); drive_req(1'b1, 1'b1, 11'h021, 16'hBBBB); settle();
        chk("st_adr1", bus.wb_adr, 32'h020);
        step(); drive_req(1'b1, 1'b1, 11'h022, 16'hCCCC); drive_slv(1'b1, 1'b1, 16'h0000); settle();
        chk("st_adr_s1", bus.wb_adr, 32'h021);
        chk("st_dat_s1", bus.wb_dat_o, 32'hBBBB);
        chk("st_ready_s1", bus.req_ready, 32'd0);
        step(); drive_slv(1'b0, 1'b1, 16'h0000); settle();
        chk("st_adr_s2", bus.wb_adr, 32'h021);
        chk("st_ready_s2", bus.req_ready, 32'd0);
        chk("st_rsp1", bus.rsp_valid, 32'd1);
        chk("st_rsp1_we", bus.rsp_we, 32'd1);
        step(); settle();
        chk("st_dat_s3", bus.wb_dat_o, 32'hBBBB);
        chk("st_ready_s3", bus.req_ready, 32'd0);
        chk("st_stb_s3", bus.wb_stb, 32'd1);
        step(); drive_slv(1'b0, 1'b0, 16'h0000); settle();
        chk("st_adr_s4", bus.wb_adr, 32'h021);
        chk("st_dat_s4", bus.wb_dat_o, 32'hBBBB);
        chk("st_ready_go", bus.req_ready, 32'd1);
        step(); drive_req(1'b0, 1'b0, 11'h000, 16'h0000); drive_slv(1'b1, 1'b0, 16'h0000); settle();
        chk("st_adr3", bus.wb_adr, 32'h022);
        chk("st_dat3", bus.wb_dat_o, 32'hCCCC);
        step(); settle();
        chk("st_rsp2", bus.rsp_valid, 32'd1);
        chk("st_stb_end", bus.wb_stb, 32'd0);
        step(); drive_slv(1'b0, 1'b0, 16'h0000); settle();
        chk("st_rsp3", bus.rsp_valid, 32'd1);
        chk("st_cyc_drop", bus.wb_cyc, 32'd0);
        step(); settle();
        chk("st_rsp_end", bus.rsp_valid, 32'd0);

        // Five queued reads against MAX_OUT=4 with the first ACK ten cycles late.
        step(); drive_req(1'b1, 1'b0, 11'h030, 16'h0000); settle();
        step(); drive_req(1'b1, 1'b0, 11'h031, 16'h0000); settle();
        step(); drive_req(1'b1, 1'b0, 11'h032, 16'h0000); settle();
        step(); drive_req(1'b1, 1'b0, 11'h033, 16'h0000); settle();
        chk("mo_ready3", bus.req_ready, 32'd1);
        step(); drive_req(1'b1, 1'b0, 11'h034, 16'h0000); settle();
        chk("mo_full_a", bus.req_ready, 32'd0);
        chk("mo_adr4", bus.wb_adr, 32'h033);
        step(); settle();
        chk("mo_full_b", bus.req_ready, 32'd0);
        chk("mo_stb_idle", bus.wb_stb, 32'd0);
        for (int i = 6; i < 12; i++) begin
            step(); settle();
            chk("mo_full_wait", bus.req_ready, 32'd0);
        end
        step(); drive_slv(1'b1, 1'b0, 16'h0A01); settle();
        chk("mo_full_ack", bus.req_ready, 32'd0);
        step(); drive_slv(1'b0, 1'b0, 16'h0000); settle();
        chk("mo_ready_free", bus.req_ready, 32'd1);
        chk("mo_dat1", bus.rsp_dat, 32'h0A01);
        step(); drive_req(1'b0, 1'b0, 11'h000, 16'h0000); settle();
        chk("mo_stb5", bus.wb_stb, 32'd1);
        chk("mo_adr5", bus.wb_adr, 32'h034);
        chk("mo_cyc", bus.wb_cyc, 32'd1);
        step(); drive_slv(1'b1, 1'b0, 16'h0A02); settle();
        step(); drive_slv(1'b1, 1'b0, 16'h0A03); settle();
        chk("mo_dat2", bus.rsp_dat, 32'h0A02);
        step(); drive_slv(1'b1, 1'b0, 16'h0A04); settle();
        chk("mo_dat3", bus.rsp_dat, 32'h0A03);
        step(); drive_slv(1'b1, 1'b0, 16'h0A05); settle();
        chk("mo_dat4", bus.rsp_dat, 32'h0A04);
        step(); drive_slv(1'b0, 1'b0, 16'h0000); settle();
        chk("mo_dat5", bus.rsp_dat, 32'h0A05);
        chk("mo_rsp5", bus.rsp_valid, 32'd1);
        chk("mo_cyc_drop", bus.wb_cyc, 32'd0);

        // Write followed by a read: the read waits for the write to drain.
        step(); drive_req(1'b1, 1'b1, 11'h040, 16'h1234); settle();
        chk("wr_rd_ready_w", bus.req_ready, 32'd1);
        step(); drive_req(1'b1, 1'b0, 11'h041, 16'h0000); settle();
        chk("wr_rd_block1", bus.req_ready, 32'd0);
        step(); drive_slv(1'b1, 1'b0, 16'h0000); settle();
        chk("wr_rd_block2", bus.req_ready, 32'd0);
        step(); drive_slv(1'b0, 1'b0, 16'h0000); settle();
        chk("wr_rd_ready_r", bus.req_ready, 32'd1);
        chk("wr_rd_wrsp", bus.rsp_valid, 32'd1);
        chk("wr_rd_stb_wait", bus.wb_stb, 32'd0);
        step(); drive_req(1'b0, 1'b0, 11'h000, 16'h0000); settle();
        chk("wr_rd_stb", bus.wb_stb, 32'd1);
        chk("wr_rd_we", bus.wb_we, 32'd0);
        chk("wr_rd_adr", bus.wb_adr, 32'h041);
        step(); drive_slv(1'b1, 1'b0, 16'h5678); settle();
        step(); drive_slv(1'b0, 1'b0, 16'h0000); settle();
        chk("wr_rd_rrsp_we", bus.rsp_we, 32'd0);
        chk("wr_rd_rrsp_dat", bus.rsp_dat, 32'h5678);

        // Reset in the middle of a burst discards everything in flight.
        step(); drive_req(1'b1, 1'b0, 11'h050, 16'h0000); settle();
        step(); drive_req(1'b1, 1'b0, 11'h051, 16'h0000); settle();
        step(); drive_req(1'b1, 1'b0, 11'h052, 16'h0000); settle();
        step(); drive_req(1'b1, 1'b0, 11'h053, 16'h0000); drive_slv(1'b1, 1'b0, 16'h7777); settle();
        step(); drive_req(1'b0, 1'b0, 11'h000, 16'h0000); drive_slv(1'b0, 1'b0, 16'h0000); settle();
        chk("rm_pre_cyc", bus.wb_cyc, 32'd1);
        chk("rm_pre_stb", bus.wb_stb, 32'd1);
        chk("rm_pre_rsp", bus.rsp_valid, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rm_cyc", bus.wb_cyc, 32'd0);
        chk("rm_stb", bus.wb_stb, 32'd0);
        chk("rm_rsp", bus.rsp_valid, 32'd0);
        chk("rm_ready", bus.req_ready, 32'd0);
        step(); drive_slv(1'b1, 1'b0, 16'h8888);
        step(); reset = 1'b0;
        step(); settle();
        chk("rm_ack_ign1", bus.rsp_valid, 32'd0);
        chk("rm_cyc_idle1", bus.wb_cyc, 32'd0);
        step(); drive_slv(1'b0, 1'b0, 16'h0000); settle();
        chk("rm_ack_ign2", bus.rsp_valid, 32'd0);
        chk("rm_cyc_idle2", bus.wb_cyc, 32'd0);

        // A read that is never acknowledged.
        step(); drive_req(1'b1, 1'b0, 11'h060, 16'h0000); settle();
        chk("to_ready", bus.req_ready, 32'd1);
        step(); drive_req(1'b0, 1'b0, 11'h000, 16'h0000); settle();
        n = 1;
`ifdef WB_TIMEOUT_EN
        while (n < 400 && bus.rsp_valid !== 1'b1) begin
            step(); settle();
            n++;
        end
        chk("to_latency", n, TIMEOUT + 3);
        chk("to_rsp", bus.rsp_valid, 32'd1);
        chk("to_err", bus.rsp_err, 32'd1);
        chk("to_dat", bus.rsp_dat, 32'd0);
        chk("to_cyc", bus.wb_cyc, 32'd0);
        chk("to_stb", bus.wb_stb, 32'd0);
        step(); drive_slv(1'b1, 1'b0, 16'h9ABC); settle();
        chk("to_single", bus.rsp_valid, 32'd0);
        step(); drive_slv(1'b0, 1'b0, 16'h0000); settle();
        chk("to_late_ack", bus.rsp_valid, 32'd0);
`else
        while (n < 300 && bus.rsp_valid !== 1'b1) begin
            step(); settle();
            n++;
        end
        chk("nto_no_rsp", bus.rsp_valid, 32'd0);
        chk("nto_err", bus.rsp_err, 32'd0);
        chk("nto_cyc", bus.wb_cyc, 32'd1);
        step(); drive_slv(1'b1, 1'b0, 16'h9ABC); settle();
        step(); drive_slv(1'b0, 1'b0, 16'h0000); settle();
        chk("nto_rsp", bus.rsp_valid, 32'd1);
        chk("nto_dat", bus.rsp_dat, 32'h9ABC);
        chk("nto_err2", bus.rsp_err, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Wishbone B4 pipelined bus master for the 16-bit system bus. It is the initiator end of the bus that board I/O and the other peripheral slaves respond on.
- Converts a valid/ready command stream (USB control path or debug agent) into classic pipelined single-beat cycles.
- Returns one response per command: read data or write completion.
- Tracks outstanding transfers and keeps CYC asserted across back-to-back commands.

Parameters:
- ADR_W, 11, Wishbone word-address width.
- DAT_W, 16, data width.
- MAX_OUT, 4, maximum outstanding (issued, un-acked) transfers; range 1..15.
- TIMEOUT, 255, cycles without ACK before abort (only with WB_TIMEOUT_EN).

Ports:
- clk  in  1  single clock; also drives the bus clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when req_valid & req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_adr  in  ADR_W  word address.
- req_dat  in  DAT_W  write data.
- rsp_valid  out  1  one-cycle response pulse; no back-pressure.
- rsp_we  out  1  direction of the completed transfer.
- rsp_dat  out  DAT_W  read data (0 for writes).
- rsp_err  out  1  transfer aborted by timeout.
- wb_cyc  out  1  bus cycle.
- wb_stb  out  1  strobe.
- wb_we  out  1  write enable.
- wb_adr  out  ADR_W  address.
- wb_dat_o  out  DAT_W  write data.
- wb_dat_i  in  DAT_W  read data.
- wb_ack  in  1  acknowledge.
- wb_stall  in  1  slave stall.

Behaviour:
- Reset: clk and reset as stated above; reset is asynchronous and active-high. All outputs go to 0 immediately, the outstanding count goes to 0 and the state to IDLE. Any in-flight or pending transfer is discarded and produces no response. Deassertion is synchronous to clk.
- States:
  - IDLE: cyc=0. Goes to BUS on an accepted request.
  - BUS: cyc=1. Goes to IDLE when outstanding=0 and stb=0 at the clock edge, so cyc drops the cycle after the last ACK.
- Issue:
  - An accepted request loads wb_adr/wb_dat_o/wb_we and asserts wb_stb on the next cycle.
  - Request-to-STB latency is 1 cycle.
  - wb_stb stays high, with adr/dat/we stable, while wb_stall=1.
  - A beat is issued on a cycle with stb & !stall; that cycle increments the outstanding count.
- req_ready=1 only when all of these hold:
  - no stalled beat is pending, or the pending beat issues this cycle;
  - outstanding + pending < MAX_OUT;
  - req_we equals the current bus direction, or outstanding=0 and no beat is pending. Direction changes drain the bus first; cyc may stay high through the change.
  - timeout abort not in progress.
- Back-to-back: with stall=0, one beat issues per cycle and stb stays continuously high.
- ACK:
  - Each ACK decrements the outstanding count.
  - The following cycle pulses rsp_valid, with rsp_we the direction and rsp_dat the registered wb_dat_i (reads) or 0 (writes).
  - ACK-to-rsp_valid latency is 1 cycle. Responses come out in issue order.
- Simultaneous issue and ACK leave the count unchanged.
- ACK with outstanding=0 is a protocol violation: ignored, no response, count saturates at 0.
- Count width is 4 bits; it never exceeds MAX_OUT.
- wb_dat_o and wb_adr hold their last values when stb=0.

Optional Feature:
- Macro: WB_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter runs while outstanding>0 or a beat is stalled. It reloads to 0 on every ACK or issue.
  - On reaching TIMEOUT, the block drops cyc and stb the next cycle and clears the outstanding count and pending beat.
  - It then emits exactly one rsp_valid with rsp_err=1 and rsp_dat=0, and returns to IDLE.
  - ACKs arriving after the abort are ignored.
- Undefined: no counter; the block waits indefinitely and rsp_err is tied 0.

Test Plan:
- Single write, zero-wait slave (ACK 1 cycle after issue): req adr=0x004, dat=0x00A5, we=1 -> stb high for 1 cycle, cyc high 2 cycles, rsp_valid 2 cycles after stb with rsp_we=1, rsp_dat=0.
- Four back-to-back reads, slave returns 0x1111..0x4444: stb continuously high for 4 cycles, 4 rsp pulses in order with matching data, cyc drops after the 4th ACK.
- Stall: slave stalls 3 cycles on the 2nd beat -> adr/dat stable for 4 cycles, req_ready low during the stall, all responses correct.
- MAX_OUT=4 with ACK delayed 10 cycles: 5 queued reads -> 4 issue, req_ready low until the first ACK, then the 5th issues.
- Write then read queued back-to-back: read not accepted until the write's ACK; read stb issues at the earliest the cycle after that ACK.
- Reset asserted mid-burst with 2 outstanding -> cyc/stb/rsp_valid go 0 immediately, no responses. With WB_TIMEOUT_EN: a read that is never ACKed gives rsp_err=1 after TIMEOUT cycles and cyc=0.
